// File: rtl/nv_nvdla_sdp_mrdma_req_gen_if.sv
// Request-side bundle of the SDP MRDMA request generator: the DMA read request
// channel and the context-queue channel that must transfer in lock-step.
interface nv_nvdla_sdp_mrdma_req_gen_if;
    logic [78:0] dma_rd_req_pd;
    logic        dma_rd_req_vld;
    logic        dma_rd_req_rdy;
    logic        dma_rd_req_ram_type;
    logic [13:0] ig2cq_pd;
    logic        ig2cq_pvld;
    logic        ig2cq_prdy;

    modport master (
        output dma_rd_req_pd,
        output dma_rd_req_vld,
        input  dma_rd_req_rdy,
        output dma_rd_req_ram_type,
        output ig2cq_pd,
        output ig2cq_pvld,
        input  ig2cq_prdy
    );

    modport slave (
        input  dma_rd_req_pd,
        input  dma_rd_req_vld,
        output dma_rd_req_rdy,
        input  dma_rd_req_ram_type,
        input  ig2cq_pd,
        input  ig2cq_pvld,
        output ig2cq_prdy
    );
endinterface

// File: rtl/nv_nvdla_sdp_mrdma_req_gen.sv
// SDP MRDMA request generator: walks the cube line by line, issuing atom reads
// plus one context entry per request. NVDLA_SDP_MRDMA_REQ_PERF_EN adds a stall counter.
module nv_nvdla_sdp_mrdma_req_gen #(
    parameter int MAX_ATOMS = 8,
    parameter int AW        = 64
) (
    input  logic        nvdla_core_clk,
    input  logic        nvdla_core_rst,
    input  logic        op_load,
    input  logic [63:0] reg2dp_src_base_addr,
    input  logic [31:0] reg2dp_src_line_stride,
    input  logic [12:0] reg2dp_width,
    input  logic [12:0] reg2dp_height,
    input  logic        reg2dp_src_ram_type,
    nv_nvdla_sdp_mrdma_req_gen_if.master req_if,
    output logic        ig_done,
    output logic [31:0] dp2reg_mrdma_stall
);

    localparam logic [0:0]  ST_IDLE  = 1'b0;
    localparam logic [0:0]  ST_RUN   = 1'b1;
    localparam logic [13:0] MAX_CNT  = 14'(MAX_ATOMS);

    logic [0:0]    state_reg,     state_next;
    logic [13:0]   atom_cnt_reg,  atom_cnt_next;
    logic [12:0]   line_cnt_reg,  line_cnt_next;
    logic [AW-1:0] line_addr_reg, line_addr_next;
    logic [12:0]   width_reg,     width_next;
    logic [12:0]   height_reg,    height_next;
    logic [31:0]   stride_reg,    stride_next;
    logic          ram_type_reg,  ram_type_next;
    logic          ig_done_reg,   ig_done_next;

    logic          run;
    logic          load_accept;
    logic          fire;
    logic [13:0]   remaining;
    logic          end_of_line;
    logic          is_last;
    logic [13:0]   req_atoms;
    logic [13:0]   size_m1;
    logic [AW-1:0] req_addr;
    logic [63:0]   req_addr64;

    assign run         = (state_reg == ST_RUN);
    assign load_accept = !run && op_load;
    assign fire        = run && req_if.dma_rd_req_rdy && req_if.ig2cq_prdy;

    // A request never crosses a line: it takes whatever is left, capped at MAX_ATOMS.
    assign remaining   = {1'b0, width_reg} + 14'd1 - atom_cnt_reg;
    assign end_of_line = (remaining <= MAX_CNT);
    assign req_atoms   = end_of_line ? remaining : MAX_CNT;
    assign size_m1     = req_atoms - 14'd1;
    assign is_last     = end_of_line && (line_cnt_reg == height_reg);
    assign req_addr    = line_addr_reg + AW'({atom_cnt_reg, 5'b00000});
    assign req_addr64  = 64'(req_addr);

    // Each side is only offered when the other can accept, so they fire together.
    assign req_if.dma_rd_req_vld      = run && req_if.ig2cq_prdy;
    assign req_if.ig2cq_pvld          = run && req_if.dma_rd_req_rdy;
    assign req_if.dma_rd_req_pd       = run ? {1'b0, size_m1, req_addr64} : 79'd0;
    assign req_if.ig2cq_pd            = run ? {is_last, size_m1[12:0]} : 14'd0;
    assign req_if.dma_rd_req_ram_type = ram_type_reg;
    assign ig_done                    = ig_done_reg;

    always_comb begin
        state_next     = state_reg;
        atom_cnt_next  = atom_cnt_reg;
        line_cnt_next  = line_cnt_reg;
        line_addr_next = line_addr_reg;
        width_next     = width_reg;
        height_next    = height_reg;
        stride_next    = stride_reg;
        ram_type_next  = ram_type_reg;
        ig_done_next   = fire && is_last;

        if (load_accept) begin
            state_next     = ST_RUN;
            atom_cnt_next  = 14'd0;
            line_cnt_next  = 13'd0;
            line_addr_next = AW'(reg2dp_src_base_addr & ~64'h1F);
            width_next     = reg2dp_width;
            height_next    = reg2dp_height;
            stride_next    = reg2dp_src_line_stride;
            ram_type_next  = reg2dp_src_ram_type;
        end else if (fire) begin
            if (end_of_line) begin
                atom_cnt_next  = 14'd0;
                line_cnt_next  = line_cnt_reg + 13'd1;
                line_addr_next = line_addr_reg + AW'(stride_reg);
                if (is_last) begin
                    state_next = ST_IDLE;
                end
            end else begin
                atom_cnt_next = atom_cnt_reg + req_atoms;
            end
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            state_reg     <= ST_IDLE;
            atom_cnt_reg  <= 14'd0;
            line_cnt_reg  <= 13'd0;
            line_addr_reg <= '0;
            width_reg     <= 13'd0;
            height_reg    <= 13'd0;
            stride_reg    <= 32'd0;
            ram_type_reg  <= 1'b0;
            ig_done_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            atom_cnt_reg  <= atom_cnt_next;
            line_cnt_reg  <= line_cnt_next;
            line_addr_reg <= line_addr_next;
            width_reg     <= width_next;
            height_reg    <= height_next;
            stride_reg    <= stride_next;
            ram_type_reg  <= ram_type_next;
            ig_done_reg   <= ig_done_next;
        end
    end

`ifdef NVDLA_SDP_MRDMA_REQ_PERF_EN
    logic [31:0] stall_cnt_reg, stall_cnt_next;

    // Counts RUN cycles with no transfer; saturates and is kept after completion.
    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (load_accept) begin
            stall_cnt_next = 32'd0;
        end else if (run && !fire && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
            stall_cnt_next = stall_cnt_reg + 32'd1;
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            stall_cnt_reg <= 32'd0;
        end else begin
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    assign dp2reg_mrdma_stall = stall_cnt_reg;
`else
    assign dp2reg_mrdma_stall = 32'd0;
`endif

endmodule

// File: tb/tb_nv_nvdla_sdp_mrdma_req_gen.sv
// Directed bench for nv_nvdla_sdp_mrdma_req_gen: a negedge monitor logs every fire
// and ig_done pulse; each test task checks the log against hand-computed vectors.
module tb_nv_nvdla_sdp_mrdma_req_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_load = 1'b0;
    logic [63:0] base = 64'd0;
    logic [31:0] stride = 32'd0;
    logic [12:0] width = 13'd0;
    logic [12:0] height = 13'd0;
    logic        ram_type = 1'b0;
    logic        ig_done;
    logic [31:0] stall;

    always #5 clk = ~clk;

    nv_nvdla_sdp_mrdma_req_gen_if req_if();

    nv_nvdla_sdp_mrdma_req_gen #(.MAX_ATOMS(8), .AW(64)) dut (
        .nvdla_core_clk         (clk),
        .nvdla_core_rst         (rst),
        .op_load                (op_load),
        .reg2dp_src_base_addr   (base),
        .reg2dp_src_line_stride (stride),
        .reg2dp_width           (width),
        .reg2dp_height          (height),
        .reg2dp_src_ram_type    (ram_type),
        .req_if                 (req_if),
        .ig_done                (ig_done),
        .dp2reg_mrdma_stall     (stall)
    );

    int checks = 0;
    int errors = 0;

    logic [63:0] f_addr[$];
    logic [14:0] f_size[$];
    logic [12:0] f_cqsz[$];
    logic        f_last[$];
    int          f_cyc[$];
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;

    // Fire = both valids and both readies high at the coming edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst && req_if.dma_rd_req_vld && req_if.ig2cq_pvld &&
            req_if.dma_rd_req_rdy && req_if.ig2cq_prdy) begin
            f_addr.push_back(req_if.dma_rd_req_pd[63:0]);
            f_size.push_back(req_if.dma_rd_req_pd[78:64]);
            f_cqsz.push_back(req_if.ig2cq_pd[12:0]);
            f_last.push_back(req_if.ig2cq_pd[13]);
            f_cyc.push_back(cyc);
        end
        if (ig_done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_log();
        f_addr.delete(); f_size.delete(); f_cqsz.delete(); f_last.delete(); f_cyc.delete();
    endtask

    task automatic start(input logic [63:0] b, input logic [31:0] s,
                         input logic [12:0] w, input logic [12:0] h, input logic rt);
        base = b; stride = s; width = w; height = h; ram_type = rt;
        op_load = 1'b1;
        tick();
        op_load = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int prev = done_cnt;
        int i = 0;
        while (done_cnt == prev && i < budget) begin
            tick();
            i++;
        end
        checks++;
        if (done_cnt == prev) begin
            errors++;
            $display("FAIL %s done_timeout: got no ig_done expected pulse within %0d cycles", name, budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_if.dma_rd_req_rdy = 1'b1;
        req_if.ig2cq_prdy = 1'b1;
        tick(); tick(); tick();
        checks++; if (req_if.dma_rd_req_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b expected 0", req_if.dma_rd_req_vld); end
        checks++; if (req_if.ig2cq_pvld !== 1'b0) begin errors++; $display("FAIL reset_pvld: got %b expected 0", req_if.ig2cq_pvld); end
        checks++; if (req_if.dma_rd_req_pd !== 79'd0) begin errors++; $display("FAIL reset_pd: got %h expected 0", req_if.dma_rd_req_pd); end
        checks++; if (req_if.ig2cq_pd !== 14'd0) begin errors++; $display("FAIL reset_cq_pd: got %h expected 0", req_if.ig2cq_pd); end
        checks++; if (req_if.dma_rd_req_ram_type !== 1'b0) begin errors++; $display("FAIL reset_ram_type: got %b expected 0", req_if.dma_rd_req_ram_type); end
        checks++; if (ig_done !== 1'b0) begin errors++; $display("FAIL reset_ig_done: got %b expected 0", ig_done); end
        checks++; if (stall !== 32'd0) begin errors++; $display("FAIL reset_stall: got %0d expected 0", stall); end
        rst = 1'b0;
        tick();
        checks++; if (req_if.dma_rd_req_vld !== 1'b0) begin errors++; $display("FAIL idle_vld: got %b expected 0", req_if.dma_rd_req_vld); end
    endtask

    task automatic test_single_line();
        logic [63:0] ea [0:2];
        logic [14:0] es [0:2];
        logic        el [0:2];
        int          d0;
        ea[0] = 64'h1000; ea[1] = 64'h1100; ea[2] = 64'h1200;
        es[0] = 15'd7;    es[1] = 15'd7;    es[2] = 15'd3;
        el[0] = 1'b0;     el[1] = 1'b0;     el[2] = 1'b1;
        clear_log();
        d0 = done_cnt;
        start(64'h1000, 32'h0, 13'd19, 13'd0, 1'b1);
        checks++; if (req_if.dma_rd_req_vld !== 1'b1) begin errors++; $display("FAIL single_first_vld: got %b expected 1", req_if.dma_rd_req_vld); end
        checks++; if (req_if.dma_rd_req_ram_type !== 1'b1) begin errors++; $display("FAIL single_ram_type: got %b expected 1", req_if.dma_rd_req_ram_type); end
        wait_done(50, "single");
        tick(); tick();
        checks++; if (f_addr.size() != 3) begin errors++; $display("FAIL single_count: got %0d expected 3", f_addr.size()); end
        for (int i = 0; i < 3 && i < f_addr.size(); i++) begin
            checks++; if (f_addr[i] !== ea[i]) begin errors++; $display("FAIL single_addr[%0d]: got %h expected %h", i, f_addr[i], ea[i]); end
            checks++; if (f_size[i] !== es[i]) begin errors++; $display("FAIL single_size[%0d]: got %0d expected %0d", i, f_size[i], es[i]); end
            checks++; if (f_cqsz[i] !== es[i][12:0]) begin errors++; $display("FAIL single_cq_size[%0d]: got %0d expected %0d", i, f_cqsz[i], es[i]); end
            checks++; if (f_last[i] !== el[i]) begin errors++; $display("FAIL single_last[%0d]: got %b expected %b", i, f_last[i], el[i]); end
        end
        if (f_cyc.size() == 3) begin
            checks++; if (done_cyc != f_cyc[2] + 1) begin errors++; $display("FAIL single_done_latency: got %0d expected %0d", done_cyc - f_cyc[2], 1); end
        end
        checks++; if (done_cnt != d0 + 1) begin errors++; $display("FAIL single_done_pulses: got %0d expected 1", done_cnt - d0); end
    endtask

    task automatic test_multi_line();
        clear_log();
        start(64'h0, 32'h400, 13'd7, 13'd2, 1'b0);
        wait_done(50, "multi");
        tick();
        checks++; if (f_addr.size() != 3) begin errors++; $display("FAIL multi_count: got %0d expected 3", f_addr.size()); end
        for (int i = 0; i < 3 && i < f_addr.size(); i++) begin
            checks++; if (f_addr[i] !== 64'(i * 32'h400)) begin errors++; $display("FAIL multi_addr[%0d]: got %h expected %h", i, f_addr[i], i * 32'h400); end
            checks++; if (f_size[i] !== 15'd7) begin errors++; $display("FAIL multi_size[%0d]: got %0d expected 7", i, f_size[i]); end
            checks++; if (f_last[i] !== (i == 2)) begin errors++; $display("FAIL multi_last[%0d]: got %b expected %b", i, f_last[i], i == 2); end
        end
        checks++; if (req_if.dma_rd_req_ram_type !== 1'b0) begin errors++; $display("FAIL multi_ram_type: got %b expected 0", req_if.dma_rd_req_ram_type); end
    endtask

    task automatic test_backpressure();
        logic [78:0] snap;
        logic [31:0] stall0;
        logic [31:0] exp_stall;
        int          n0;
        clear_log();
        start(64'h2000, 32'h0, 13'd31, 13'd0, 1'b0);
        tick();
        req_if.ig2cq_prdy = 1'b0;
        #1;
        snap = req_if.dma_rd_req_pd;
        stall0 = stall;
        n0 = f_addr.size();
        checks++; if (snap[63:0] !== 64'h2100) begin errors++; $display("FAIL bp_addr: got %h expected 2100", snap[63:0]); end
        for (int c = 0; c < 5; c++) begin
            checks++; if (req_if.dma_rd_req_vld !== 1'b0) begin errors++; $display("FAIL bp_vld[%0d]: got %b expected 0", c, req_if.dma_rd_req_vld); end
            checks++; if (req_if.dma_rd_req_pd !== snap) begin errors++; $display("FAIL bp_pd[%0d]: got %h expected %h", c, req_if.dma_rd_req_pd, snap); end
            tick();
            #1;
        end
        checks++; if (f_addr.size() != n0) begin errors++; $display("FAIL bp_no_fire: got %0d expected %0d", f_addr.size(), n0); end
`ifdef NVDLA_SDP_MRDMA_REQ_PERF_EN
        exp_stall = stall0 + 32'd5;
`else
        exp_stall = 32'd0;
`endif
        checks++; if (stall !== exp_stall) begin errors++; $display("FAIL bp_stall: got %0d expected %0d", stall, exp_stall); end
        req_if.ig2cq_prdy = 1'b1;
        req_if.dma_rd_req_rdy = 1'b0;
        #1;
        checks++; if (req_if.ig2cq_pvld !== 1'b0) begin errors++; $display("FAIL bp_pvld: got %b expected 0", req_if.ig2cq_pvld); end
        tick();
        req_if.dma_rd_req_rdy = 1'b1;
        wait_done(50, "bp");
        tick();
        checks++; if (f_addr.size() != 4) begin errors++; $display("FAIL bp_count: got %0d expected 4", f_addr.size()); end
        for (int i = 0; i < 4 && i < f_addr.size(); i++) begin
            checks++; if (f_addr[i] !== 64'h2000 + 64'(i * 256)) begin errors++; $display("FAIL bp_seq_addr[%0d]: got %h expected %h", i, f_addr[i], 64'h2000 + 64'(i * 256)); end
        end
    endtask

    task automatic test_wrap();
        clear_log();
        start(64'hFFFF_FFFF_FFFF_FFE0, 32'h0, 13'd1, 13'd0, 1'b0);
        wait_done(20, "wrap1");
        tick();
        checks++; if (f_addr.size() != 1) begin errors++; $display("FAIL wrap1_count: got %0d expected 1", f_addr.size()); end
        if (f_addr.size() >= 1) begin
            checks++; if (f_addr[0] !== 64'hFFFF_FFFF_FFFF_FFE0) begin errors++; $display("FAIL wrap1_addr: got %h expected ffffffffffffffe0", f_addr[0]); end
            checks++; if (f_size[0] !== 15'd1) begin errors++; $display("FAIL wrap1_size: got %0d expected 1", f_size[0]); end
            checks++; if (f_last[0] !== 1'b1) begin errors++; $display("FAIL wrap1_last: got %b expected 1", f_last[0]); end
        end
        clear_log();
        start(64'hFFFF_FFFF_FFFF_FFE0, 32'h0, 13'd9, 13'd0, 1'b0);
        wait_done(20, "wrap2");
        tick();
        checks++; if (f_addr.size() != 2) begin errors++; $display("FAIL wrap2_count: got %0d expected 2", f_addr.size()); end
        if (f_addr.size() >= 2) begin
            checks++; if (f_addr[1] !== 64'h00E0) begin errors++; $display("FAIL wrap2_addr: got %h expected e0", f_addr[1]); end
            checks++; if (f_size[1] !== 15'd1) begin errors++; $display("FAIL wrap2_size: got %0d expected 1", f_size[1]); end
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        clear_log();
        d0 = done_cnt;
        start(64'h5000, 32'h1000, 13'd15, 13'd2, 1'b1);
        tick(); tick();
        rst = 1'b1;
        tick();
        checks++; if (req_if.dma_rd_req_vld !== 1'b0) begin errors++; $display("FAIL rstmid_vld: got %b expected 0", req_if.dma_rd_req_vld); end
        checks++; if (req_if.ig2cq_pvld !== 1'b0) begin errors++; $display("FAIL rstmid_pvld: got %b expected 0", req_if.ig2cq_pvld); end
        checks++; if (f_addr.size() != 2) begin errors++; $display("FAIL rstmid_fires: got %0d expected 2", f_addr.size()); end
        rst = 1'b0;
        repeat (4) tick();
        checks++; if (done_cnt != d0) begin errors++; $display("FAIL rstmid_no_done: got %0d expected 0", done_cnt - d0); end
        clear_log();
        start(64'h5000, 32'h1000, 13'd15, 13'd2, 1'b1);
        wait_done(50, "rstmid");
        tick();
        checks++; if (f_addr.size() != 6) begin errors++; $display("FAIL rstmid_count: got %0d expected 6", f_addr.size()); end
        if (f_addr.size() == 6) begin
            checks++; if (f_addr[0] !== 64'h5000) begin errors++; $display("FAIL rstmid_first: got %h expected 5000", f_addr[0]); end
            checks++; if (f_addr[5] !== 64'h7100) begin errors++; $display("FAIL rstmid_final: got %h expected 7100", f_addr[5]); end
        end
    endtask

    task automatic test_restart();
        logic [63:0] ea [0:5];
        ea[0] = 64'h8000; ea[1] = 64'h8100; ea[2] = 64'h8200;
        ea[3] = 64'h8200; ea[4] = 64'h8300; ea[5] = 64'h8400;
        clear_log();
        start(64'h8000, 32'h200, 13'd23, 13'd1, 1'b0);
        tick();
        base = 64'h9000; width = 13'd0; height = 13'd0; ram_type = 1'b1;
        op_load = 1'b1;
        tick();
        op_load = 1'b0;
        wait_done(50, "restart");
        tick();
        checks++; if (f_addr.size() != 6) begin errors++; $display("FAIL restart_count: got %0d expected 6", f_addr.size()); end
        for (int i = 0; i < 6 && i < f_addr.size(); i++) begin
            checks++; if (f_addr[i] !== ea[i]) begin errors++; $display("FAIL restart_addr[%0d]: got %h expected %h", i, f_addr[i], ea[i]); end
        end
        checks++; if (req_if.dma_rd_req_ram_type !== 1'b0) begin errors++; $display("FAIL restart_ram_type: got %b expected 0", req_if.dma_rd_req_ram_type); end
    endtask

    task automatic test_back_to_back();
        clear_log();
        start(64'hA000, 32'h0, 13'd0, 13'd0, 1'b0);
        tick();
        checks++; if (ig_done !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b expected 1", ig_done); end
        base = 64'hB000;
        op_load = 1'b1;
        tick();
        op_load = 1'b0;
        #1;
        checks++; if (req_if.dma_rd_req_vld !== 1'b1) begin errors++; $display("FAIL b2b_vld: got %b expected 1", req_if.dma_rd_req_vld); end
        checks++; if (req_if.dma_rd_req_pd[63:0] !== 64'hB000) begin errors++; $display("FAIL b2b_addr: got %h expected b000", req_if.dma_rd_req_pd[63:0]); end
        wait_done(20, "b2b");
        tick();
        checks++; if (f_addr.size() != 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", f_addr.size()); end
    endtask

    initial begin
        req_if.dma_rd_req_rdy = 1'b1;
        req_if.ig2cq_prdy = 1'b1;
        test_reset();
        test_single_line();
        test_multi_line();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_restart();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nv_nvdla_sdp_mrdma_req_gen.md
# nv_nvdla_sdp_mrdma_req_gen

Upstream request generator for the SDP memory-read DMA. On each `op_load` it walks the configured cube line by line. It issues 32-byte-atom read requests to the DMA read interface. For every issued request it pushes one matching entry into the context queue, which the MRDMA egress consumes to reassemble returned data.

## Interface
Parameters:
- `MAX_ATOMS`, 8: maximum atoms per request (power of two, 1..8).
- `AW`, 64: address width.

Ports:
- `nvdla_core_clk`, in, 1: core clock.
- `nvdla_core_rst`, in, 1: synchronous, active-high reset.
- `op_load`, in, 1: start pulse. Configuration registers are sampled on this cycle.
- `reg2dp_src_base_addr`, in, 64: cube base address, 32B aligned (bits [4:0] ignored).
- `reg2dp_src_line_stride`, in, 32: byte stride between lines, 32B aligned.
- `reg2dp_width`, in, 13: atoms per line minus 1.
- `reg2dp_height`, in, 13: lines minus 1.
- `reg2dp_src_ram_type`, in, 1: source RAM select.
- `dma_rd_req_pd`, out, 79: request payload. Bits [63:0] are the address; bits [78:64] are the atom count minus 1.
- `dma_rd_req_vld`, out, 1: request valid.
- `dma_rd_req_rdy`, in, 1: request ready.
- `dma_rd_req_ram_type`, out, 1: RAM type latched at `op_load`.
- `ig2cq_pd`, out, 14: context entry. Bits [12:0] are the atom count minus 1; bit [13] marks the last request of the cube.
- `ig2cq_pvld`, out, 1: context entry valid.
- `ig2cq_prdy`, in, 1: context queue ready.
- `ig_done`, out, 1: one-cycle pulse after the last request is issued.
- `dp2reg_mrdma_stall`, out, 32: stall-cycle count (see Configuration).

## Operation
- States:
  - IDLE → RUN on `op_load`.
  - RUN → IDLE on the fire of the request with bit [13] set.
  - `op_load` is ignored in RUN.
- On `op_load`, latch all `reg2dp_*` inputs. Clear `atom_cnt` and `line_cnt`, and set `line_addr` to the base address.
- Handshakes:
  - `dma_rd_req_vld` = RUN & `ig2cq_prdy`.
  - `ig2cq_pvld` = RUN & `dma_rd_req_rdy`.
  - fire = RUN & `dma_rd_req_rdy` & `ig2cq_prdy`.
  - Both sides therefore transfer in the same cycle or not at all.
- Request size: n = min(`MAX_ATOMS`, remaining atoms in line), where remaining = width+1−`atom_cnt`.
- Request address = `line_addr` + `atom_cnt`*32. Requests never span lines.
- On fire:
  - If not at end of line: `atom_cnt` += n.
  - At end of line: `atom_cnt` := 0, `line_cnt` += 1, `line_addr` += stride.
- Last request: end of line with `line_cnt` == height. `ig_done` pulses the cycle after its fire.
- Address arithmetic wraps modulo 2^`AW`, with no error.
- The payload is combinational from the counters and stays stable while valid and unfired.
- Reset mid-operation: returns to IDLE and drops both valids on the next edge. No `ig_done` is produced.

## Timing
- Reset values: both valids 0, `dma_rd_req_pd` 0, `ig2cq_pd` 0, `dma_rd_req_ram_type` 0, `ig_done` 0, `dp2reg_mrdma_stall` 0. State is IDLE.
- The first request is valid in the cycle after `op_load`.
- With both readies held high, throughput is one request per cycle.
- Total requests = (height+1)*ceil((width+1)/`MAX_ATOMS`).
- `ig_done` is registered, one cycle after the final fire.
- Back-to-back: a new `op_load` is accepted in the same cycle `ig_done` is high.

## Configuration
- Macro: `NVDLA_SDP_MRDMA_REQ_PERF_EN`.
- Defined:
  - `dp2reg_mrdma_stall` counts cycles in RUN without a fire.
  - The count saturates at 0xFFFFFFFF and clears on `op_load`.
  - The value holds after completion until the next `op_load`.
- Undefined: the counter is not instantiated and `dp2reg_mrdma_stall` is tied to 0.

## Test plan
- Single-line cube:
  - Stimulus: base 0x1000, width 19 (20 atoms), height 0, `MAX_ATOMS` 8, readies high.
  - Required: requests (0x1000, size 7), (0x1100, size 7), (0x1200, size 3). The last one has `ig2cq_pd` bit 13 set. `ig_done` pulses 1 cycle later.
- Multi-line stride:
  - Stimulus: width 7, height 2, stride 0x400, base 0.
  - Required: addresses 0x0, 0x400, 0x800, each size 7. Exactly 3 fires.
- Backpressure:
  - Stimulus: hold `ig2cq_prdy` low for 5 cycles mid-line.
  - Required: `dma_rd_req_vld` is low for those cycles, the payload is unchanged, and no fire occurs.
  - With PERF_EN, `dp2reg_mrdma_stall` increases by 5.
- Address wrap:
  - Stimulus: base 0xFFFF_FFFF_FFFF_FFE0, width 1.
  - Required: second atom addressed at 0x0 (single request of size 1, bit 13 set).
- Reset mid-cube:
  - Stimulus: assert `nvdla_core_rst` after 2 fires of a 6-request cube.
  - Required: valids go to 0 the next cycle and no `ig_done`.
  - A following `op_load` restarts from the base address.
- Restart protection:
  - Stimulus: pulse `op_load` during RUN.
  - Required: the sequence is unaffected and the request count is unchanged.
